// File: rtl/fmpadding_cfg.sv
// Feature-map padding stage: wraps each frame of a SIMD-folded NHWC stream in pad beats,
// with geometry and pad value staged and committed only between frames.
module fmpadding_cfg_lane #(
    parameter int ELEM_BITS = 8
) (
    input  logic                 use_pad,
    input  logic [ELEM_BITS-1:0] pad,
    input  logic [ELEM_BITS-1:0] data,
    output logic [ELEM_BITS-1:0] out
);
    assign out = use_pad ? pad : data;
endmodule

module fmpadding_cfg #(
    parameter int XCOUNTER_BITS = 12,
    parameter int YCOUNTER_BITS = 12,
    parameter int NUM_CHANNELS  = 4,
    parameter int SIMD          = 1,
    parameter int ELEM_BITS     = 8,
    localparam int STREAM_BITS  = 8 * ((SIMD * ELEM_BITS + 7) / 8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_wa,
    input  logic [31:0]            cfg_wd,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tvalid,
    input  logic [STREAM_BITS-1:0] s_axis_tdata,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [STREAM_BITS-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   frame_done,
    output logic                   busy
);
    localparam int SF        = NUM_CHANNELS / SIMD;
    localparam int SW        = (SF > 1) ? $clog2(SF) : 1;
    localparam int LANE_BITS = SIMD * ELEM_BITS;

    if (NUM_CHANNELS % SIMD != 0) begin : g_bad_fold
        $error("fmpadding_cfg: NUM_CHANNELS must be a multiple of SIMD");
    end

    typedef struct packed {
        logic [XCOUNTER_BITS-1:0] xon, xoff, xend;
        logic [YCOUNTER_BITS-1:0] yon, yoff, yend;
        logic [ELEM_BITS-1:0]     pad;
    } cfg_t;

    cfg_t stg, act, eff;
    logic commit_pending, enabled, started;
    logic [SW-1:0]            s_cnt;
    logic [XCOUNTER_BITS-1:0] x_cnt;
    logic [YCOUNTER_BITS-1:0] y_cnt;
    logic                     a_vld, b_vld, b_last;
    logic [STREAM_BITS-1:0]   a_data, b_data, src_data, gen_data;
    logic commit_now, en_eff, fwd, b_slot, s_hs, src_rdy, gen, last_beat, unused_wd;

    // !started implies the counters sit at the origin. A pending commit is
    // bypassed straight into the generator so a new frame starts without a bubble.
    assign commit_now = commit_pending && !started;
    assign eff        = commit_now ? stg : act;
    assign en_eff     = enabled || commit_now;

    assign fwd = (x_cnt >= eff.xon) && (x_cnt < eff.xoff) &&
                 (y_cnt >= eff.yon) && (y_cnt < eff.yoff);

    assign s_axis_tready = enabled && !a_vld;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign b_slot        = m_axis_tready || !b_vld;
    assign src_rdy       = a_vld || s_hs;
    assign gen           = en_eff && b_slot && (!fwd || src_rdy);
    assign src_data      = a_vld ? a_data : s_axis_tdata;
    assign last_beat     = (s_cnt == SW'(SF - 1)) && (x_cnt == eff.xend) && (y_cnt == eff.yend);

    for (genvar l = 0; l < SIMD; l++) begin : g_lane
        fmpadding_cfg_lane #(.ELEM_BITS(ELEM_BITS)) u_lane (
            .use_pad (!fwd),
            .pad     (eff.pad),
            .data    (src_data[l*ELEM_BITS +: ELEM_BITS]),
            .out     (gen_data[l*ELEM_BITS +: ELEM_BITS])
        );
    end

    if (STREAM_BITS > LANE_BITS) begin : g_fill
        assign gen_data[STREAM_BITS-1:LANE_BITS] = fwd ? src_data[STREAM_BITS-1:LANE_BITS] : '0;
    end

    assign unused_wd     = ^cfg_wd;
    assign m_axis_tvalid = b_vld;
    assign m_axis_tdata  = b_data;
    assign m_axis_tlast  = b_last;
    assign frame_done    = b_vld && b_last && m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg            <= '0;
            act            <= '0;
            commit_pending <= 1'b0;
            enabled        <= 1'b0;
        end else begin
            if (commit_now) begin
                act            <= stg;
                enabled        <= 1'b1;
                commit_pending <= 1'b0;
            end
            if (cfg_we) begin
                case (cfg_wa)
                    4'd0:    stg.xon  <= cfg_wd[XCOUNTER_BITS-1:0];
                    4'd1:    stg.xoff <= cfg_wd[XCOUNTER_BITS-1:0];
                    4'd2:    stg.xend <= cfg_wd[XCOUNTER_BITS-1:0];
                    4'd4:    stg.yon  <= cfg_wd[YCOUNTER_BITS-1:0];
                    4'd5:    stg.yoff <= cfg_wd[YCOUNTER_BITS-1:0];
                    4'd6:    stg.yend <= cfg_wd[YCOUNTER_BITS-1:0];
                    4'd8:    stg.pad  <= cfg_wd[ELEM_BITS-1:0];
                    4'd15:   commit_pending <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_cnt   <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            started <= 1'b0;
            a_vld   <= 1'b0;
            a_data  <= '0;
            b_vld   <= 1'b0;
            b_data  <= '0;
            b_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (gen) begin
                b_data  <= gen_data;
                b_last  <= last_beat;
                started <= !last_beat;
                if (s_cnt == SW'(SF - 1)) begin
                    s_cnt <= '0;
                    if (x_cnt == eff.xend) begin
                        x_cnt <= '0;
                        y_cnt <= (y_cnt == eff.yend) ? '0 : y_cnt + 1'b1;
                    end else begin
                        x_cnt <= x_cnt + 1'b1;
                    end
                end else begin
                    s_cnt <= s_cnt + 1'b1;
                end
            end
            if (b_slot) b_vld <= gen;
            // Input lands in A only when it cannot go straight into B this cycle.
            if (s_hs && !(gen && fwd)) begin
                a_vld  <= 1'b1;
                a_data <= s_axis_tdata;
            end else if (gen && fwd && a_vld) begin
                a_vld <= 1'b0;
            end
            busy <= (busy && !frame_done) || (gen && !started);
        end
    end
endmodule

// File: tb/tb_fmpadding_cfg.sv
// Bench for fmpadding_cfg: randomized handshakes checked against a frame-level model
// that enumerates rows/columns/folds and pulls input beats in order.
module tb_fmpadding_cfg;
    localparam int SF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_wa;
    logic [31:0] cfg_wd;
    logic        s_axis_tready, s_axis_tvalid;
    logic [15:0] s_axis_tdata;
    logic        m_axis_tready, m_axis_tvalid, m_axis_tlast;
    logic [15:0] m_axis_tdata;
    logic        frame_done, busy;

    fmpadding_cfg #(.NUM_CHANNELS(4), .SIMD(2), .ELEM_BITS(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_wa(cfg_wa), .cfg_wd(cfg_wd),
        .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int xon, xoff, xend, yon, yoff, yend; logic [7:0] pad; } cfg_s;
    typedef struct { logic [15:0] data; logic last; } beat_t;
    typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;

    beat_t       exp_q[$];
    logic [15:0] in_list[$];
    wr_t         wq[$];
    int          in_idx, model_k, cfg_trig;
    int          checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame model: raster order y, x, fold; forwarded positions consume the next input beat.
    task automatic model_frame(input cfg_s c);
        beat_t b;
        for (int y = 0; y <= c.yend; y++)
            for (int x = 0; x <= c.xend; x++)
                for (int s = 0; s < SF; s++) begin
                    if (x >= c.xon && x < c.xoff && y >= c.yon && y < c.yoff) begin
                        b.data = in_list[model_k];
                        model_k++;
                    end else begin
                        b.data = {c.pad, c.pad};
                    end
                    b.last = (y == c.yend) && (x == c.xend) && (s == SF - 1);
                    exp_q.push_back(b);
                end
    endtask

    task automatic new_scenario();
        exp_q.delete();
        in_list.delete();
        wq.delete();
        for (int i = 0; i < 200; i++) in_list.push_back(16'($urandom));
        in_idx = 0;
        model_k = 0;
        cfg_trig = 0;
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_wa = a;
        cfg_wd = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic program_cfg(input cfg_s c);
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        cfg_wr(4'd0, 32'(c.xon));
        cfg_wr(4'd1, 32'(c.xoff));
        cfg_wr(4'd2, 32'(c.xend));
        cfg_wr(4'd4, 32'(c.yon));
        cfg_wr(4'd5, 32'(c.yoff));
        cfg_wr(4'd6, 32'(c.yend));
        cfg_wr(4'd8, 32'(c.pad));
        cfg_wr(4'd15, 32'hDEAD_BEEF);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_we = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_mvalid", m_axis_tvalid, 0);
        check("rst_sready", s_axis_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_fdone", frame_done, 0);
    endtask

    // Runs until the expected queue drains, stop_beats beats are seen, or budget expires.
    task automatic run(input int p_rdy, input int p_vld, input int stop_beats, input int budget,
                       output int span);
        int cyc, beats, first_cyc, last_cyc;
        logic prev_stall, prev_l;
        logic [15:0] prev_d;
        beat_t e;
        wr_t w;
        cyc = 0; beats = 0; first_cyc = -1; last_cyc = -1;
        prev_stall = 1'b0; prev_l = 1'b0; prev_d = '0;
        while (exp_q.size() > 0 && beats < stop_beats && cyc < budget) begin
            m_axis_tready = ($urandom_range(99) < p_rdy);
            s_axis_tvalid = ($urandom_range(99) < p_vld);
            s_axis_tdata  = (in_idx < in_list.size()) ? in_list[in_idx] : '0;
            if (beats >= cfg_trig && wq.size() > 0) begin
                w = wq.pop_front();
                cfg_we = 1'b1; cfg_wa = w.a; cfg_wd = w.d;
            end else begin
                cfg_we = 1'b0;
            end
            #1;
            if (prev_stall) begin
                check("hold_data", m_axis_tdata, prev_d);
                check("hold_last", m_axis_tlast, prev_l);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                e = exp_q.pop_front();
                check($sformatf("data_b%0d", beats + 1), m_axis_tdata, e.data);
                check($sformatf("last_b%0d", beats + 1), m_axis_tlast, e.last);
                check($sformatf("fdone_b%0d", beats + 1), frame_done, e.last);
                beats++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end else begin
                check("fdone_idle", frame_done, 0);
            end
            if (s_axis_tvalid && s_axis_tready) in_idx++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
            tick();
            cyc++;
        end
        check("budget", (cyc < budget), 1);
        cfg_we = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        span = last_cyc - first_cyc + 1;
    endtask

    initial begin
        cfg_s base, allpad, shadow;
        int span;
        rst = 1'b1; cfg_we = 1'b0; cfg_wa = '0; cfg_wd = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
        base = '{xon: 1, xoff: 3, xend: 3, yon: 1, yoff: 3, yend: 3, pad: 8'h5A};
        allpad = base; allpad.xon = 2; allpad.xoff = 2;
        shadow = base; shadow.xoff = 2; shadow.pad = 8'h00;

        // Gating: nothing moves before the first commit
        do_reset();
        for (int i = 0; i < 20; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 16'($urandom);
            m_axis_tready = 1'b1;
            #1;
            check("gate_sready", s_axis_tready, 0);
            check("gate_mvalid", m_axis_tvalid, 0);
            tick();
        end
        s_axis_tvalid = 1'b0;

        // All-pad frame, no input offered
        new_scenario();
        program_cfg(allpad);
        model_frame(allpad);
        run(100, 0, 1000, 500, span);
        check("allpad_consumed", in_idx, 0);

        // Basic padding, always-ready sinks
        do_reset();
        new_scenario();
        program_cfg(base);
        model_frame(base);
        run(100, 100, 1000, 500, span);
        check("basic_inputs_model", model_k, 8);

        // Backpressure on both sides
        do_reset();
        new_scenario();
        program_cfg(base);
        model_frame(base);
        run(50, 50, 1000, 2000, span);

        // Shadowing: reprogram mid-frame, takes effect on the next frame
        do_reset();
        new_scenario();
        program_cfg(base);
        model_frame(base);
        model_frame(shadow);
        wq.push_back('{a: 4'd8, d: 32'h0});
        wq.push_back('{a: 4'd1, d: 32'd2});
        wq.push_back('{a: 4'd15, d: 32'h0});
        cfg_trig = 10;
        run(50, 70, 1000, 3000, span);

        // Reset mid-frame, then restart cleanly
        do_reset();
        new_scenario();
        program_cfg(base);
        model_frame(base);
        run(100, 100, 10, 500, span);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("midrst_mvalid", m_axis_tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sready", s_axis_tready, 0);
        rst = 1'b0;
        tick();
        new_scenario();
        program_cfg(base);
        model_frame(base);
        run(100, 100, 1000, 500, span);

        // Back-to-back frames with no idle cycle
        do_reset();
        new_scenario();
        program_cfg(base);
        model_frame(base);
        model_frame(base);
        model_frame(base);
        run(100, 100, 1000, 500, span);
        check("b2b_span", span, 96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmpadding_cfg.md
Name: fmpadding_cfg

Overview:
- Next-generation feature-map padding stage for the streaming dataflow pipeline. Sits between a producer of unpadded NHWC pixels and a sliding-window generator.
- Inserts padding beats around each frame on a SIMD-folded channel stream.
- Adds over the previous generation:
  - a runtime-programmable pad value;
  - double-buffered (shadowed) geometry committed only at frame boundaries;
  - an output end-of-frame marker (tlast);
  - frame status outputs.

Parameters:
XCOUNTER_BITS, 12, width of column counter and X config fields
YCOUNTER_BITS, 12, width of row counter and Y config fields
NUM_CHANNELS, 4, channels per pixel; must be a SIMD multiple, else elaboration error
SIMD, 1, elements per stream beat
ELEM_BITS, 8, bits per element
STREAM_BITS, derived, 8*ceil(SIMD*ELEM_BITS/8); not overridable

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_we  in  1  config write strobe
cfg_wa  in  4  config register address
cfg_wd  in  32  config write data (LSB-aligned, truncated to field width)
s_axis_tready  out  1  input ready
s_axis_tvalid  in  1  input valid
s_axis_tdata  in  STREAM_BITS  input pixel slice
m_axis_tready  in  1  output ready
m_axis_tvalid  out  1  output valid
m_axis_tdata  out  STREAM_BITS  output pixel slice
m_axis_tlast  out  1  last beat of frame
frame_done  out  1  one-cycle pulse when the tlast beat handshakes
busy  out  1  high from first beat of a frame until its tlast handshake

Behaviour:
- Staging register map: 0 XOn, 1 XOff, 2 XEnd, 4 YOn, 5 YOff, 6 YEnd, 8 PadVal (ELEM_BITS).
  - Writing address 15 (data ignored) sets the commit_pending flag.
  - Writes to any other address are silently ignored.
- Active set is loaded from staging, and commit_pending is cleared, only when the block is at a frame boundary and commit_pending=1.
  - Frame boundary: counters at origin and no beat of the current frame yet generated.
  - Staging writes mid-frame never affect the running frame.
- After reset, the enabled flag is 0. No beats are generated and s_axis_tready=0 until the first commit loads the active set; commit sets enabled=1.
- Nested counters, cascaded:
  - S counts SIMD folds 0..SF-1, where SF=NUM_CHANNELS/SIMD.
  - X counts 0..XEnd and advances when S wraps.
  - Y counts 0..YEnd and advances when X wraps.
  - Y wraps to 0 after YEnd; the frame ends there.
- Forwarding rule: fwd = (XOn<=X<XOff) && (YOn<=Y<YOff), unsigned compares.
  - When fwd=1, the beat is taken from input.
  - Otherwise a pad beat is emitted: PadVal replicated across all SIMD lanes, upper filler bits 0.
  - XOn>=XOff or YOn>=YOff gives an all-pad frame, with no input consumed.
- Buffering: two-entry skid (A input holding, B output register).
  - s_axis_tready = enabled && !A.vld.
  - m_axis_tvalid/tdata/tlast are B, registered.
  - B loads whenever (m_axis_tready || !B.vld), from pad, A, or s_axis in that priority given fwd.
  - Counters advance exactly when B loads a new beat.
  - Latency: input accepted at cycle n appears on m_axis at n+1 when the output is not stalled.
  - Sustained throughput is 1 beat/cycle with both sides always ready.
- m_axis_tlast = 1 on the beat generated at S=SF-1, X=XEnd, Y=YEnd.
- frame_done pulses the cycle m_axis_tvalid && m_axis_tready && m_axis_tlast.
- Frame-end and new frame in the same cycle:
  - If commit_pending is set at the wrap, the new active set applies from the very next beat.
  - No bubble is inserted.
- Holding rule: m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid && !m_axis_tready.
- Reset (also mid-frame):
  - counters to origin;
  - A and B invalid;
  - m_axis_tvalid=0, m_axis_tlast=0, frame_done=0, busy=0, s_axis_tready=0;
  - staging and active registers cleared to 0;
  - commit_pending=0, enabled=0.

Test Plan:
- Basic padding, with NUM_CHANNELS=4, SIMD=2, ELEM_BITS=8:
  - Stimulus: write XOn=1, XOff=3, XEnd=3, YOn=1, YOff=3, YEnd=3, PadVal=0x5A, commit; stream a 2x2 image with always-ready sinks.
  - Required: 32 output beats; 8 input beats forwarded at positions (1..2,1..2); all others 0x5A5A.
  - Required: tlast only on beat 32; one frame_done pulse.
- Backpressure:
  - Stimulus: same config; toggle m_axis_tready randomly at 50% and s_axis_tvalid randomly.
  - Required: output sequence identical to the basic case; tdata/tlast stable while stalled; no input beat dropped or duplicated.
- Shadowing:
  - Stimulus: mid-frame, write PadVal=0x00, XOff=2, then commit.
  - Required: current frame completes with 0x5A pads and 32 beats.
  - Required: next frame uses 0x00 pads and 1-column input (4 input beats per frame).
- Gating and all-pad:
  - Stimulus: after reset with no commit, drive s_axis_tvalid=1 for 20 cycles.
  - Required: s_axis_tready=0 and m_axis_tvalid=0 throughout.
  - Stimulus: then commit with XOn=2, XOff=2.
  - Required: all-pad frame; zero inputs consumed.
- Reset mid-frame:
  - Stimulus: assert rst after 10 output beats.
  - Required: next cycle m_axis_tvalid=0 and busy=0.
  - Required: after recommit, the frame restarts at beat 1 with correct tlast at beat 32.
- Back-to-back frames:
  - Stimulus: 3 consecutive frames with continuous ready/valid.
  - Required: 96 beats with no idle cycle between frames; frame_done pulses at beats 32, 64, 96.
